// File: rtl/i2s_receiver.sv
// I2S record-path receiver: oversamples bclk/lrc/dat on mclk, deserialises
// left/right words and presents each stereo pair on a valid/ready output.
module i2s_receiver #(
  parameter int SAMPLE_BITS = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic                   audio_I2S_bclk,
  input  logic                   audio_I2S_reclrc,
  input  logic                   audio_I2S_recdat,
  output logic [SAMPLE_BITS-1:0] rx_left,
  output logic [SAMPLE_BITS-1:0] rx_right,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic                   frame_err
);

  localparam int CW = $clog2(SAMPLE_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(SAMPLE_BITS);

  typedef enum logic [1:0] {HUNT, DELAY, SHIFT, HOLD} state_t;
  state_t state;

  logic [SYNC_STAGES-1:0] bclk_sync, lrc_sync, dat_sync;
  logic                   bclk_d;
  logic                   bit_tick, lrc_s, dat_s, lrc_change;
  logic                   lrc_prev, channel, left_valid, pair_stb;
  logic [CW-1:0]          cnt, cnt_next;
  logic [SAMPLE_BITS-1:0] shreg, shifted, left_hold, right_hold;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      bclk_sync <= '0;
      lrc_sync  <= '0;
      dat_sync  <= '0;
      bclk_d    <= 1'b0;
    end else begin
      bclk_sync[0] <= audio_I2S_bclk;
      lrc_sync[0]  <= audio_I2S_reclrc;
      dat_sync[0]  <= audio_I2S_recdat;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        bclk_sync[i] <= bclk_sync[i-1];
        lrc_sync[i]  <= lrc_sync[i-1];
        dat_sync[i]  <= dat_sync[i-1];
      end
      bclk_d <= bclk_sync[SYNC_STAGES-1];
    end
  end

  assign bit_tick   = bclk_sync[SYNC_STAGES-1] & ~bclk_d;
  assign lrc_s      = lrc_sync[SYNC_STAGES-1];
  assign dat_s      = dat_sync[SYNC_STAGES-1];
  assign lrc_change = lrc_s != lrc_prev;
  assign shifted    = {shreg[SAMPLE_BITS-2:0], dat_s};
  assign cnt_next   = (cnt == FULL) ? FULL : cnt + CW'(1);

  // The tick on which lrc changes carries the previous word's LSB and is the
  // new word's delay slot; DELAY only lasts one mclk cycle before SHIFT.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      lrc_prev   <= 1'b0;
      channel    <= 1'b0;
      cnt        <= '0;
      shreg      <= '0;
      left_hold  <= '0;
      right_hold <= '0;
      left_valid <= 1'b0;
      pair_stb   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      pair_stb  <= 1'b0;
      frame_err <= 1'b0;
      if (state == DELAY) begin
        cnt   <= '0;
        shreg <= '0;
        state <= SHIFT;
      end else if (bit_tick) begin
        lrc_prev <= lrc_s;
        case (state)
          HUNT: begin
            if (lrc_prev && !lrc_s) begin
              channel    <= 1'b0;
              left_valid <= 1'b0;
              cnt        <= '0;
              state      <= DELAY;
            end
          end
          SHIFT: begin
            shreg <= shifted;
            cnt   <= cnt_next;
            if (cnt_next == FULL) begin
              if (!channel) begin
                left_hold  <= shifted;
                left_valid <= 1'b1;
              end else begin
                right_hold <= shifted;
                if (left_valid) begin
                  pair_stb   <= 1'b1;
                  left_valid <= 1'b0;
                end
              end
              state <= HOLD;
            end else if (lrc_change) begin
              frame_err  <= 1'b1;
              left_valid <= 1'b0;
            end
          end
          default: ;
        endcase
        if (lrc_change && (state == SHIFT || state == HOLD)) begin
          channel <= lrc_s;
          cnt     <= '0;
          state   <= DELAY;
          if (!lrc_s) left_valid <= 1'b0;
        end
      end
    end
  end

  // Output handshake: a pair is transferred on every mclk edge where
  // rx_valid and rx_ready are both 1; rx_left/rx_right hold while rx_valid=1
  // and rx_ready=0, and a pair arriving then is dropped and flagged.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      rx_left  <= '0;
      rx_right <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (pair_stb && (!rx_valid || rx_ready)) begin
        rx_left  <= left_hold;
        rx_right <= right_hold;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (pair_stb && rx_valid && !rx_ready) overrun <= 1'b1;
      else if (overrun_clr)                  overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: drives I2S frames at bclk = mclk/16
// and scoreboards every accepted stereo pair against a queue of expected pairs.
module tb_i2s_receiver;

  localparam int W = 16;

  logic         mclk = 1'b0;
  logic         rst = 1'b1;
  logic         bclk = 1'b0;
  logic         lrc = 1'b0;
  logic         dat = 1'b0;
  logic         rx_ready = 1'b1;
  logic         overrun_clr = 1'b0;
  logic [W-1:0] rx_left, rx_right;
  logic         rx_valid, overrun, frame_err;

  logic [2*W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pairs_seen = 0;
  int pairs_exp = 0;
  int fe_cycles = 0;
  logic carry = 1'b0;

  i2s_receiver #(.SAMPLE_BITS(W), .SYNC_STAGES(2)) dut (
    .mclk             (mclk),
    .rst              (rst),
    .audio_I2S_bclk   (bclk),
    .audio_I2S_reclrc (lrc),
    .audio_I2S_recdat (dat),
    .rx_left          (rx_left),
    .rx_right         (rx_right),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .overrun          (overrun),
    .overrun_clr      (overrun_clr),
    .frame_err        (frame_err)
  );

  // clock / reset
  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  // driver tasks
  task automatic send_bit(input logic l, input logic d);
    @(posedge mclk);
    #1;
    bclk = 1'b0;
    lrc  = l;
    dat  = d;
    repeat (8) @(posedge mclk);
    #1;
    bclk = 1'b1;
    repeat (7) @(posedge mclk);
  endtask

  // One lrc half of nbits bclks: first bit carries the previous word's LSB,
  // then the word MSB first, then junk if the slot is longer than the word.
  task automatic send_half(input logic l, input logic [W-1:0] word, input int nbits);
    logic d;
    for (int i = 0; i < nbits; i++) begin
      if (i == 0)          d = carry;
      else if (i - 1 < W)  d = word[W-i];
      else                 d = 1'($urandom_range(0, 1));
      send_bit(l, d);
    end
    if (nbits - 1 < W) carry = word[W-nbits];
    else               carry = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int nbits);
    send_half(1'b0, l, nbits);
    send_half(1'b1, r, nbits);
  endtask

  task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    exp_q.push_back({l, r});
    pairs_exp++;
  endtask

  task automatic flush();
    send_half(1'b0, W'($urandom), 1);
    wait_cycles(4);
  endtask

  task automatic start_scenario();
    @(posedge mclk);
    #1;
    rst  = 1'b1;
    bclk = 1'b0;
    pairs_seen = 0;
    pairs_exp  = 0;
    fe_cycles  = 0;
    exp_q.delete();
    wait_cycles(4);
    rst = 1'b0;
    send_half(1'b1, W'($urandom), W);
  endtask

  task automatic end_scenario(input string tag, input int fe_exp);
    check({tag, "_pairs"}, pairs_seen, pairs_exp);
    check({tag, "_frame_err"}, fe_cycles, fe_exp);
  endtask

  // scoreboard
  always @(negedge mclk) begin
    if (!rst) begin
      if (frame_err) fe_cycles++;
      if (rx_valid && rx_ready) begin
        pairs_seen++;
        if (exp_q.size() > 0) check("pair", {rx_left, rx_right}, exp_q.pop_front());
      end
    end
  end

  initial begin
    wait_cycles(4);
    check("reset_valid", rx_valid, 0);
    check("reset_left", rx_left, 0);
    check("reset_right", rx_right, 0);
    check("reset_overrun", overrun, 0);
    check("reset_frame_err", frame_err, 0);

    // nominal
    start_scenario();
    push_pair(16'hA55A, 16'h1234);
    send_frame(16'hA55A, 16'h1234, W);
    flush();
    end_scenario("nominal", 0);

    // backpressure: second pair is dropped
    start_scenario();
    rx_ready = 1'b0;
    push_pair(16'h0001, 16'h0002);
    send_frame(16'h0001, 16'h0002, W);
    send_frame(16'h0003, 16'h0004, W);
    flush();
    check("bp_valid", rx_valid, 1);
    check("bp_left", rx_left, 16'h0001);
    check("bp_right", rx_right, 16'h0002);
    check("bp_overrun", overrun, 1);
    overrun_clr = 1'b1;
    wait_cycles(1);
    overrun_clr = 1'b0;
    wait_cycles(2);
    check("bp_overrun_clr", overrun, 0);
    rx_ready = 1'b1;
    wait_cycles(4);
    end_scenario("backpressure", 0);

    // short right word
    start_scenario();
    send_half(1'b0, 16'h5555, W);
    send_half(1'b1, 16'h0F0F, 11);
    push_pair(16'h7FFF, 16'h8000);
    send_frame(16'h7FFF, 16'h8000, W);
    flush();
    end_scenario("short_word", 1);

    // reset released mid right word
    @(posedge mclk);
    #1;
    rst = 1'b1;
    pairs_seen = 0;
    pairs_exp  = 0;
    fe_cycles  = 0;
    exp_q.delete();
    send_half(1'b0, W'($urandom), W);
    send_half(1'b1, W'($urandom), 6);
    @(posedge mclk);
    #1;
    rst = 1'b0;
    send_half(1'b1, W'($urandom), 10);
    push_pair(16'h0F0F, 16'hF0F0);
    send_frame(16'h0F0F, 16'hF0F0, W);
    flush();
    end_scenario("startup", 0);

    // long slot with trailing junk
    start_scenario();
    push_pair(16'hBEEF, 16'hCAFE);
    send_frame(16'hBEEF, 16'hCAFE, 2 * W);
    flush();
    end_scenario("long_slot", 0);

    // async reset at bit 7 of a left word
    start_scenario();
    push_pair(16'h1357, 16'h2468);
    send_frame(16'h1357, 16'h2468, W);
    send_half(1'b0, 16'hABCD, 8);
    @(posedge mclk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_left", rx_left, 0);
    check("arst_right", rx_right, 0);
    check("arst_valid", rx_valid, 0);
    bclk = 1'b0;
    wait_cycles(4);
    rst = 1'b0;
    send_half(1'b1, W'($urandom), W);
    push_pair(16'h6789, 16'h9876);
    send_frame(16'h6789, 16'h9876, W);
    flush();
    end_scenario("arst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
